// File: rtl/bldc_pkg.sv
// Shared BLDC definitions: the six-state Hall commutation table,
// step direction codes and helpers for walking the table.
package bldc_pkg;

  localparam int HALL_STEPS = 6;
  localparam logic DIR_FWD = 1'b0;
  localparam logic DIR_REV = 1'b1;

  // Valid Hall codes {C,B,A} in forward commutation order.
  localparam logic [2:0] HALL_SEQ [0:5] = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b100, 3'b101};

  // Position within HALL_SEQ; only the six valid encodings are ever reached.
  typedef enum logic [2:0] {
    IDX0 = 3'd0,
    IDX1 = 3'd1,
    IDX2 = 3'd2,
    IDX3 = 3'd3,
    IDX4 = 3'd4,
    IDX5 = 3'd5
  } hall_idx_e;

  // Next table position, wrapping at either end.
  function automatic hall_idx_e step_idx(input hall_idx_e idx, input logic dir);
    hall_idx_e res;
    if (dir == DIR_FWD) begin
      res = (idx == IDX5) ? IDX0 : hall_idx_e'(idx + 3'd1);
    end else begin
      res = (idx == IDX0) ? IDX5 : hall_idx_e'(idx - 3'd1);
    end
    return res;
  endfunction

  // Hall code for a table position; unused encodings fall back to the reset code.
  function automatic logic [2:0] hall_of(input hall_idx_e idx);
    logic [2:0] code;
    case (idx)
      IDX0:    code = HALL_SEQ[0];
      IDX1:    code = HALL_SEQ[1];
      IDX2:    code = HALL_SEQ[2];
      IDX3:    code = HALL_SEQ[3];
      IDX4:    code = HALL_SEQ[4];
      IDX5:    code = HALL_SEQ[5];
      default: code = HALL_SEQ[0];
    endcase
    return code;
  endfunction

endpackage

// File: rtl/hall_sensor_simulator_if.sv
// Control and output bundle of the Hall sensor simulator.
// master: the controller / bench side; slave: the simulator itself.
interface hall_sensor_simulator_if #(
  parameter int CNT_W    = 32,
  parameter int STROBE_W = 16
);
  logic                enable_sim;
  logic                sim_direction;
  logic [CNT_W-1:0]    sim_speed_duration;
  logic [STROBE_W-1:0] strobe_pulse_duration;
  logic [2:0]          simulated_hall;
  logic                hall_sample_strobe;

  modport master (
    output enable_sim, sim_direction, sim_speed_duration, strobe_pulse_duration,
    input  simulated_hall, hall_sample_strobe
  );

  modport slave (
    input  enable_sim, sim_direction, sim_speed_duration, strobe_pulse_duration,
    output simulated_hall, hall_sample_strobe
  );
endinterface

// File: rtl/hall_strobe_gen.sv
// Load/countdown pulse stretcher: a step pulse raises the strobe for
// exactly `duration` cycles; a new step while still high reloads it.
module hall_strobe_gen #(
  parameter int STROBE_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                step_pulse,
  input  logic [STROBE_W-1:0] duration,
  output logic                strobe
);

  logic [STROBE_W-1:0] cnt_reg;
  logic [STROBE_W-1:0] cnt_next;
  logic                strobe_reg;
  logic                strobe_next;

  // Next strobe state: load on step, count down while nonzero, cleared when frozen.
  always_comb begin
    cnt_next    = cnt_reg;
    strobe_next = 1'b0;
    if (!enable) begin
      cnt_next    = '0;
      strobe_next = 1'b0;
    end else if (step_pulse) begin
      if (duration == '0) begin
        cnt_next    = '0;
        strobe_next = 1'b0;
      end else begin
        cnt_next    = duration - STROBE_W'(1);
        strobe_next = 1'b1;
      end
    end else if (cnt_reg != '0) begin
      cnt_next    = cnt_reg - STROBE_W'(1);
      strobe_next = 1'b1;
    end
  end

  // Strobe register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg    <= '0;
      strobe_reg <= 1'b0;
    end else begin
      cnt_reg    <= cnt_next;
      strobe_reg <= strobe_next;
    end
  end

  assign strobe = strobe_reg;

endmodule

// File: rtl/hall_sensor_simulator.sv
// Synthetic Hall sensor: steps through the six valid Hall codes every
// P = max(sim_speed_duration, 2) cycles, forward or reverse, with a
// sample strobe starting on each change.
module hall_sensor_simulator
  import bldc_pkg::*;
#(
  parameter int CNT_W    = 32,
  parameter int STROBE_W = 16
) (
  input  logic clk,
  input  logic reset,
  hall_sensor_simulator_if.slave sim_if
);

  logic [CNT_W-1:0] period_eff;
  logic [CNT_W-1:0] period_cnt_reg;
  logic [CNT_W-1:0] period_cnt_next;
  hall_idx_e        idx_reg;
  hall_idx_e        idx_next;
  logic [2:0]       hall_reg;
  logic [2:0]       hall_next;
  logic             step_pulse;

  // Effective period, clamping 0 and 1 up to 2.
  always_comb begin
    period_eff = (sim_if.sim_speed_duration < CNT_W'(2)) ? CNT_W'(2) : sim_if.sim_speed_duration;
  end

  // Period counter and index next-state; ">=" lets a shortened period wrap at once.
  always_comb begin
    step_pulse      = 1'b0;
    period_cnt_next = period_cnt_reg;
    idx_next        = idx_reg;
    hall_next       = hall_reg;
    if (sim_if.enable_sim) begin
      if (period_cnt_reg >= period_eff - CNT_W'(1)) begin
        step_pulse      = 1'b1;
        period_cnt_next = '0;
        idx_next        = step_idx(idx_reg, sim_if.sim_direction);
        hall_next       = hall_of(idx_next);
      end else begin
        period_cnt_next = period_cnt_reg + CNT_W'(1);
      end
    end
  end

  // State register: counter, index and the registered Hall code.
  always_ff @(posedge clk) begin
    if (reset) begin
      period_cnt_reg <= '0;
      idx_reg        <= IDX0;
      hall_reg       <= HALL_SEQ[0];
    end else begin
      period_cnt_reg <= period_cnt_next;
      idx_reg        <= idx_next;
      hall_reg       <= hall_next;
    end
  end

  hall_strobe_gen #(
    .STROBE_W (STROBE_W)
  ) u_strobe (
    .clk        (clk),
    .reset      (reset),
    .enable     (sim_if.enable_sim),
    .step_pulse (step_pulse),
    .duration   (sim_if.strobe_pulse_duration),
    .strobe     (sim_if.hall_sample_strobe)
  );

  assign sim_if.simulated_hall = hall_reg;

endmodule

// File: tb/tb_hall_sensor_simulator.sv
// Directed bench for hall_sensor_simulator: a small cycle model tracks
// the expected Hall code and strobe; directed checks pin key edges.
module tb_hall_sensor_simulator;

  logic clk;
  logic reset;

  hall_sensor_simulator_if #(.CNT_W(32), .STROBE_W(16)) hif ();

  hall_sensor_simulator #(.CNT_W(32), .STROBE_W(16)) dut (
    .clk    (clk),
    .reset  (reset),
    .sim_if (hif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests  = 0;
  int failed = 0;

  logic [2:0] seq [0:5];
  int exp_idx   = 0;
  int exp_cnt   = 0;
  int since     = 1000;
  int strobe_len = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: advance the model with the inputs in force at the rising edge, then compare at the falling edge.
  task automatic tick();
    int p;
    p = (hif.sim_speed_duration < 2) ? 2 : int'(hif.sim_speed_duration);
    if (reset) begin
      exp_idx = 0; exp_cnt = 0; since = 1000; strobe_len = 0;
    end else if (!hif.enable_sim) begin
      since = 1000; strobe_len = 0;
    end else if (exp_cnt >= p - 1) begin
      exp_cnt    = 0;
      exp_idx    = hif.sim_direction ? (exp_idx + 5) % 6 : (exp_idx + 1) % 6;
      since      = 0;
      strobe_len = int'(hif.strobe_pulse_duration);
    end else begin
      exp_cnt++;
      if (since < 1000) since++;
    end
    @(negedge clk);
    check("hall", {29'd0, hif.simulated_hall}, {29'd0, seq[exp_idx]});
    check("strobe", {31'd0, hif.hall_sample_strobe}, {31'd0, since < strobe_len});
    check("hall_valid", {31'd0, (hif.simulated_hall != 3'b000) && (hif.simulated_hall != 3'b111)}, 32'd1);
    $display("[TB] t=%0t rst=%0b en=%0b dir=%0b P=%0d hall=%03b strobe=%0b", $time, reset,
             hif.enable_sim, hif.sim_direction, p, hif.simulated_hall, hif.hall_sample_strobe);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  logic [2:0] held;
  int guard;

  initial begin
    seq[0] = 3'b001; seq[1] = 3'b011; seq[2] = 3'b010;
    seq[3] = 3'b110; seq[4] = 3'b100; seq[5] = 3'b101;

    reset = 1'b1;
    hif.enable_sim = 1'b0;
    hif.sim_direction = 1'b0;
    hif.sim_speed_duration = 32'd10;
    hif.strobe_pulse_duration = 16'd3;
    @(negedge clk);
    run(2);
    check("reset_hall", {29'd0, hif.simulated_hall}, 32'h1);
    check("reset_strobe", {31'd0, hif.hall_sample_strobe}, 32'd0);

    // Forward run, P=10, strobe 3: first change on the 10th edge.
    reset = 1'b0;
    hif.enable_sim = 1'b1;
    run(9);
    check("first_hold", {29'd0, hif.simulated_hall}, 32'h1);
    tick();
    check("first_step", {29'd0, hif.simulated_hall}, 32'h3);
    check("first_strobe", {31'd0, hif.hall_sample_strobe}, 32'd1);
    run(2);
    check("strobe_2", {31'd0, hif.hall_sample_strobe}, 32'd1);
    tick();
    check("strobe_end", {31'd0, hif.hall_sample_strobe}, 32'd0);
    run(47);
    check("fwd_wrap", {29'd0, hif.simulated_hall}, 32'h1);

    // Direction flip mid-period: current period completes, then reverse.
    run(3);
    hif.sim_direction = 1'b1;
    run(6);
    check("rev_hold", {29'd0, hif.simulated_hall}, 32'h1);
    tick();
    check("rev_first", {29'd0, hif.simulated_hall}, 32'h5);
    run(10);
    check("rev_second", {29'd0, hif.simulated_hall}, 32'h4);
    run(40);
    check("rev_wrap", {29'd0, hif.simulated_hall}, 32'h1);

    // Freeze at count 4 for 25 cycles; next change 6 cycles after re-enable.
    guard = 0;
    while (exp_cnt != 4 && guard < 20) begin tick(); guard++; end
    check("reach_cnt4", guard < 20 ? 32'd1 : 32'd0, 32'd1);
    held = hif.simulated_hall;
    hif.enable_sim = 1'b0;
    run(25);
    check("freeze_hall", {29'd0, hif.simulated_hall}, {29'd0, held});
    check("freeze_strobe", {31'd0, hif.hall_sample_strobe}, 32'd0);
    hif.enable_sim = 1'b1;
    run(5);
    check("resume_hold", {29'd0, hif.simulated_hall}, {29'd0, held});
    tick();
    check("resume_step", {31'd0, hif.simulated_hall != held}, 32'd1);

    // Clamped periods: duration 0 and 1 both step every 2 cycles.
    hif.sim_direction = 1'b0;
    hif.sim_speed_duration = 32'd0;
    run(12);
    hif.sim_speed_duration = 32'd1;
    run(12);

    // Strobe width 0 never asserts; 15 with P=10 stays high.
    hif.sim_speed_duration = 32'd10;
    hif.strobe_pulse_duration = 16'd0;
    run(30);
    hif.strobe_pulse_duration = 16'd15;
    run(40);
    check("strobe_cont", {31'd0, hif.hall_sample_strobe}, 32'd1);

    // Mid-period reset in state 110.
    hif.strobe_pulse_duration = 16'd3;
    guard = 0;
    while (!(exp_idx == 3 && exp_cnt == 4) && guard < 200) begin tick(); guard++; end
    check("reach_110", {29'd0, hif.simulated_hall}, 32'h6);
    reset = 1'b1;
    tick();
    check("rst_hall", {29'd0, hif.simulated_hall}, 32'h1);
    check("rst_strobe", {31'd0, hif.hall_sample_strobe}, 32'd0);
    reset = 1'b0;
    run(9);
    check("rst_hold", {29'd0, hif.simulated_hall}, 32'h1);
    tick();
    check("rst_first", {29'd0, hif.simulated_hall}, 32'h3);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
